// File: rtl/bus_cycle_scheduler_if.sv
// -----------------------------------------------------------------------------
// bus_cycle_scheduler_if
// Purpose : groups the host-bus inputs, the strobe configuration and the
//           scheduler outputs of bus_cycle_scheduler into one bundle.
// Signals :
//   i_e           host phase-2 clock (asynchronous to the FPGA clock)
//   i_write_n     host R/W, 1 = read (asynchronous)
//   i_offsets     per-channel phase offset, channel i at [i*CNT_W +: CNT_W]
//   i_modes       per-channel qualifier, channel i at [2*i +: 2]
//   o_strobe      one-clock strobes, one bit per channel
//   o_cycle_start high in the clock where the phase count is 0 after an E fall
//   o_period      FPGA clocks between the last two E falls (saturating)
//   o_locked      E period stable
//   o_timeout     phase counter saturated (E lost)
// Modports: master drives the inputs (host side / bench), slave is the
//           scheduler.
// Flow control: there is no valid/ready handshake. The host pins are
// free-running and sampled every clock; the configuration is quasi-static
// and may change at any time (one strobe may be dropped or duplicated); the
// outputs are qualified only by themselves (o_strobe / o_cycle_start pulses,
// o_locked / o_timeout levels).
// -----------------------------------------------------------------------------
interface bus_cycle_scheduler_if #(
    parameter int CNT_W     = 5,
    parameter int N_STROBES = 4
);
    logic                         i_e;
    logic                         i_write_n;
    logic [N_STROBES*CNT_W-1:0]   i_offsets;
    logic [2*N_STROBES-1:0]       i_modes;
    logic [N_STROBES-1:0]         o_strobe;
    logic                         o_cycle_start;
    logic [CNT_W-1:0]             o_period;
    logic                         o_locked;
    logic                         o_timeout;

    modport master (
        output i_e, i_write_n, i_offsets, i_modes,
        input  o_strobe, o_cycle_start, o_period, o_locked, o_timeout
    );

    modport slave (
        input  i_e, i_write_n, i_offsets, i_modes,
        output o_strobe, o_cycle_start, o_period, o_locked, o_timeout
    );
endinterface

// File: rtl/bus_cycle_scheduler.sv
// -----------------------------------------------------------------------------
// bus_cycle_scheduler
// Purpose : synchronises the host E clock and R/W into the FPGA clock domain,
//           counts FPGA clocks from each E falling edge and decodes
//           N_STROBES programmable strobes from that phase count. Also
//           measures the E period, reports lock and flags loss of E.
// Ports   :
//   i_clk    FPGA clock
//   i_reset  synchronous, active-high reset
//   bus      bus_cycle_scheduler_if.slave (host pins, config, outputs)
// -----------------------------------------------------------------------------
module bus_cycle_scheduler #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 5,
    parameter int N_STROBES   = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    bus_cycle_scheduler_if.slave  bus
);

    localparam logic [CNT_W-1:0] MAX = '1;
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [SYNC_STAGES-1:0] e_sync_q;
    logic [SYNC_STAGES-1:0] wn_sync_q;
    logic                   e_d_q;
    logic [CNT_W-1:0]       q_q;
    logic [CNT_W-1:0]       q_d;
    logic [CNT_W-1:0]       period_q;
    logic [CNT_W-1:0]       period_d;
    logic                   locked_q;
    logic                   locked_d;
    logic                   cycle_start_q;

    logic                   e_s;
    logic                   wn_s;
    logic                   fall;
    logic                   q_sat;
    logic [CNT_W-1:0]       p_new;
    logic [CNT_W-1:0]       p_diff;
    logic                   lock_ok;

    assign e_s   = e_sync_q[SYNC_STAGES-1];
    assign wn_s  = wn_sync_q[SYNC_STAGES-1];
    // A cleared chain holds e_d = e_s = 0, so no fall can appear after reset.
    assign fall  = e_d_q & ~e_s;
    assign q_sat = (q_q == MAX);

    // Period of the cycle that just ended; a saturated counter means the
    // length is unknown, reported as MAX.
    assign p_new  = q_sat ? MAX : q_q + ONE;
    assign p_diff = (p_new >= period_q) ? (p_new - period_q) : (period_q - p_new);
    // Old period 0 (nothing measured yet) or MAX (E was lost) never locks.
    assign lock_ok = (p_new != MAX) && (period_q != '0) && (period_q != MAX)
                     && (p_diff <= ONE);

    always_comb begin
        q_d      = q_q;
        period_d = period_q;
        locked_d = locked_q;
        if (fall) begin
            q_d      = '0;
            period_d = p_new;
            locked_d = lock_ok;
        end else begin
            if (!q_sat) begin
                q_d = q_q + ONE;
            end
            // Lock drops as soon as the counter arrives at saturation.
            if (q_d == MAX) begin
                locked_d = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            e_sync_q      <= '0;
            wn_sync_q     <= '0;
            e_d_q         <= 1'b0;
            q_q           <= MAX;
            period_q      <= '0;
            locked_q      <= 1'b0;
            cycle_start_q <= 1'b0;
        end else begin
            e_sync_q      <= {e_sync_q[SYNC_STAGES-2:0], bus.i_e};
            wn_sync_q     <= {wn_sync_q[SYNC_STAGES-2:0], bus.i_write_n};
            e_d_q         <= e_s;
            q_q           <= q_d;
            period_q      <= period_d;
            locked_q      <= locked_d;
            cycle_start_q <= fall;
        end
    end

    // Mode 00 always, 01 read only, 10 write only, 11 disabled.
    function automatic logic qual_fn(input logic [1:0] mode, input logic wn);
        logic r;
        case (mode)
            2'b00:   r = 1'b1;
            2'b01:   r = wn;
            2'b10:   r = ~wn;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Strobes decode registered state only; q == MAX suppresses them so an
    // offset of MAX never fires.
    always_comb begin
        bus.o_strobe = '0;
        for (int i = 0; i < N_STROBES; i++) begin
            bus.o_strobe[i] = (q_q == bus.i_offsets[i*CNT_W +: CNT_W]) && !q_sat
                              && qual_fn(bus.i_modes[2*i +: 2], wn_s);
        end
    end

    assign bus.o_cycle_start = cycle_start_q;
    assign bus.o_period      = period_q;
    assign bus.o_locked      = locked_q;
    assign bus.o_timeout     = q_sat;

endmodule

// File: doc/bus_cycle_scheduler.md
Name: bus_cycle_scheduler

Overview:
Parametrised successor to the cartridge-bus cycle scheduler. It synchronises the host phase-2 clock (E) and host R/W into the FPGA clock domain, counts FPGA clocks from each detected E falling edge, and generates N independently programmable strobes. Each strobe has its own offset and read/write qualification. The block also measures the E period, flags loss of E (timeout) and reports lock, so downstream bus logic can refuse to act on an unstable host clock.

Parameters:
SYNC_STAGES, 2, synchroniser flops on i_e and i_write_n (>=2)
CNT_W, 5, phase counter / period width; saturation value MAX = 2^CNT_W-1
N_STROBES, 4, number of strobe channels

Ports:
i_clk  in  1  FPGA clock
i_reset  in  1  synchronous, active-high reset
i_e  in  1  host phase-2 clock, asynchronous
i_write_n  in  1  host R/W (1 = read), asynchronous
i_offsets  in  N_STROBES*CNT_W  strobe i fires at phase count i_offsets[i*CNT_W +: CNT_W]
i_modes  in  2*N_STROBES  per channel: 00 always, 01 read cycles only, 10 write cycles only, 11 disabled
o_strobe  out  N_STROBES  one-clock strobes
o_cycle_start  out  1  high for the clock in which phase count == 0 following an E fall
o_period  out  CNT_W  clocks between the last two E falls (saturating)
o_locked  out  1  E period stable
o_timeout  out  1  phase counter saturated (E lost)

Behaviour:
- Reset is synchronous and active-high. Reset values: sync chains = 0, delayed-E = 0, phase q = MAX, o_period = 0, o_locked = 0, o_cycle_start = 0. Therefore o_strobe = 0 and o_timeout = 1 from the cycle after reset.
- Sync: i_e and i_write_n each pass through SYNC_STAGES flops, giving e_s and wn_s. e_d is e_s delayed one clock. fall = e_d & ~e_s.
- A cleared chain (all 0) cannot produce a fall, so there is no spurious edge after reset even if E is high.
- Latency: if i_e is first sampled low at edge t0, fall is true after edge t0+SYNC_STAGES-1, and q = 0 after edge t0+SYNC_STAGES.
- Counter:
  - On fall, q <= 0.
  - Otherwise, if q != MAX, q <= q+1.
  - Otherwise q holds at MAX. The counter saturates and never wraps.
- o_cycle_start = registered fall, which coincides with q == 0 after an edge.
- Strobes are combinational decodes of registered state:
  - o_strobe[i] = (q == off_i) & (q != MAX) & qual_i.
  - qual_i: mode 00 -> 1; mode 01 -> wn_s; mode 10 -> ~wn_s; mode 11 -> 0.
  - An offset equal to MAX never fires.
  - i_offsets and i_modes are quasi-static; a change takes effect on the next clock and may drop or duplicate one strobe.
- Period: on fall, o_period <= (q == MAX) ? MAX : q+1. Otherwise o_period holds.
- Lock: on fall, compute new period p as above.
  - o_locked <= 1 iff p != MAX, old o_period is not in {0, MAX}, and |p - old o_period| <= 1.
  - Otherwise o_locked <= 0.
  - o_locked also clears in any cycle where q reaches MAX.
- o_timeout = (q == MAX).
  - Fall while saturated: q <= 0, so o_timeout deasserts next cycle; o_period <= MAX and o_locked stays 0.
- Reset mid-operation overrides everything, including a fall in the same cycle: that edge is lost.
- Several strobes may fire in the same clock if their offsets are equal.

Test Plan:
1. Reset, then i_e held high for 40 clocks -> o_strobe = 0, o_cycle_start = 0, o_timeout = 1, o_period = 0, o_locked = 0 throughout.
2. E period 12 clocks (6 high / 6 low), i_write_n = 1, ch0 offset 7 mode 00, ch1 offset 5 mode 01 ->
   - ch1 pulses 1 clock after edge t0+7; ch0 pulses after edge t0+9.
   - o_period = 31 after the first fall, 12 after the second.
   - o_locked = 1 after the third fall.
3. Same stimulus with i_write_n = 0, ch2 offset 5 mode 10, ch3 mode 11 ->
   - ch1 silent, ch2 pulses once per cycle, ch3 never fires.
   - ch0 unaffected.
4. Locked at period 12, then E held low for 40 clocks ->
   - q saturates at 31; o_timeout = 1 and o_locked = 0 from then on.
   - No strobes after q = 31.
   - When E resumes, the first period reads 31, and lock returns only after two periods of 12.
5. Period jitter: periods 12, 13, 12 -> lock held; then a period of 15 -> o_locked = 0 after that fall.
6. i_reset pulsed for 1 clock at q = 4 with E high ->
   - Next cycle: q = 31, all strobes 0, o_period = 0, o_locked = 0.
   - No o_cycle_start until a genuine E fall is seen.
